fpu_operand_deser: RTL
======================

// Module: fpu_operand_deser
// PURPOSE
//  Input front-end of the FPU chip; sits directly upstream of the FP16 add/mul core.
//  Collects two half-precision operands delivered nibble-serially on the chip pins
//  (A on io_in[3:0], B on io_in[7:4], op select on io_in[8], frame enable on io_in[9]).
//  Presents them to the core as one parallel {op_a, op_b, op_sel} word through a
//  valid/ready handshake, with a one-entry output register.
// PARAMETERS
//  NIB_W    4  bits per nibble lane
//  NUM_NIB  4  nibbles per operand, LS nibble first; operand width = NIB_W*NUM_NIB = 16
//  LEAD     1  setup cycles after frame start before the first nibble is sampled (>=0)
// PORTS
//  clock      in   1      single clock; all sampling on rising edge
//  reset      in   1      asynchronous, active-high; clears all state and outputs
//  in_en      in   1      frame enable (io_in[9]); high for the whole frame
//  in_sel     in   1      1 = add, 0 = multiply (io_in[8])
//  in_a_nib   in   NIB_W  operand A nibble (io_in[3:0])
//  in_b_nib   in   NIB_W  operand B nibble (io_in[7:4])
//  op_a       out  16     assembled operand A
//  op_b       out  16     assembled operand B
//  op_sel     out  1      select latched for this frame
//  op_valid   out  1      output register holds an unconsumed operand pair
//  op_ready   in   1      core accepts the pair on an edge where op_valid&&op_ready
//  busy       out  1      1 whenever state != IDLE
//  frame_err  out  1      one-cycle pulse: frame aborted (in_en low before last nibble)
//  overrun    out  1      one-cycle pulse: completed frame discarded, output slot full
// BEHAVIOUR
//  Reset: state=IDLE; op_a=op_b=0; op_sel=op_valid=busy=frame_err=overrun=0; counters 0.
//   Reset asserted mid-frame discards the partial frame; no error pulse is raised.
//  FSM states IDLE, LEAD, CAP, WAIT_LOW:
//   IDLE:     in_en=1 at edge E0 -> latch in_sel; go LEAD (or CAP if LEAD==0).
//   LEAD:     count LEAD edges with in_en=1; nibble pins ignored; then go CAP.
//   CAP:      edge k (k=0..NUM_NIB-1) writes in_a_nib/in_b_nib into bits [4k+3:4k] of
//             shadow regs. On edge NUM_NIB-1 the full word (shadow + incoming nibble)
//             is offered to the output slot in that same edge; go WAIT_LOW.
//   WAIT_LOW: stay while in_en=1 (extra enable cycles ignored); in_en=0 -> IDLE.
//             Exactly one frame per in_en high pulse.
//  Abort: in_en=0 sampled in LEAD or CAP -> IDLE; frame_err=1 for the next cycle only;
//   output slot untouched.
//  Output slot (registered, no comb path from pins to op_*):
//   Slot is free if op_valid=0, or op_valid&&op_ready on the same edge.
//   Completion + free -> op_a/op_b/op_sel loaded, op_valid=1 after that edge.
//    Latency with LEAD=1: in_en sampled at E0, nibbles at E1..E4, op_valid high after E4.
//   Completion + not free -> new frame dropped; overrun=1 for one cycle; slot keeps old data.
//   op_valid&&op_ready with no completion -> op_valid=0 after the edge.
//   op_a/op_b/op_sel held stable while op_valid&&!op_ready.
//  Widths: no arithmetic on operand data; nibble counter is clog2(NUM_NIB) bits and
//   never wraps past NUM_NIB-1.
//  busy is combinational from state only.
// TESTING
//  1 op_ready=1, in_en high 7 cycles, sel=1, A=5051 B=5051 (nibbles LS first)
//    -> op_valid 1 cycle after E4; op_a=5051 op_b=5051 op_sel=1; one accept.
//  2 op_ready=0, frame sel=0 A=5007 B=D007; op_ready raised 3 cycles after op_valid
//    -> op_* stable throughout; op_valid drops the edge after ready.
//  3 op_ready=0, frames A=4D3D/B=48EA then A=4976/B=426C
//    -> overrun pulses once at second completion; op_a=4D3D op_b=48EA retained.
//  4 in_en drops after 2 nibbles, then full frame A=03FF B=0001 sel=1
//    -> frame_err 1-cycle pulse; no op_valid for aborted frame; second gives 03FF/0001.
//  5 reset asserted between edges during CAP
//    -> all outputs 0 immediately (async, no edge); next frame A=7BFF B=7BFF captured correctly.
//  6 op_ready=1, in_en held high 12 cycles with changing nibbles
//    -> exactly one op_valid pulse; data = nibbles at E1..E4 only.

Source files
------------

// File: rtl/fpu_operand_deser_if.sv
// Parallel operand bus between the nibble deserialiser and the FP16 add/mul core.
// The producer drives the operand pair and valid; the consumer drives ready.
interface fpu_operand_deser_if #(
    parameter int OP_W = 16
);
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic            op_sel;
    logic            op_valid;
    logic            op_ready;

    modport master (
        output op_a,
        output op_b,
        output op_sel,
        output op_valid,
        input  op_ready
    );

    modport slave (
        input  op_a,
        input  op_b,
        input  op_sel,
        input  op_valid,
        output op_ready
    );
endinterface

// File: rtl/fpu_operand_deser.sv
// FPU input front-end: assembles two nibble-serial half-precision operands plus
// the add/multiply select into one parallel word and hands it to the core
// through a one-entry registered valid/ready slot.
//
// Frame timing: the edge that first sees in_en high (E0) is itself the first
// setup cycle, so with LEAD=1 nibbles are taken on E1..E(NUM_NIB). LEAD=0
// behaves like LEAD=1 because E0 is always spent recognising the frame.
module fpu_operand_deser #(
    parameter int NIB_W   = 4,
    parameter int NUM_NIB = 4,
    parameter int LEAD    = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in_en,
    input  logic               in_sel,
    input  logic [NIB_W-1:0]   in_a_nib,
    input  logic [NIB_W-1:0]   in_b_nib,
    fpu_operand_deser_if.master core_bus,
    output logic               busy,
    output logic               frame_err,
    output logic               overrun
);
    localparam int OP_W   = NIB_W * NUM_NIB;
    localparam int CNT_W  = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam int LCNT_W = (LEAD > 1) ? $clog2(LEAD) : 1;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LEAD     = 2'd1;
    localparam logic [1:0] ST_CAP      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW = 2'd3;

    localparam logic [CNT_W-1:0]  NIB_LAST  = CNT_W'(NUM_NIB - 1);
    localparam logic [LCNT_W-1:0] LEAD_LAST = LCNT_W'((LEAD > 1) ? (LEAD - 1) : 0);

    logic [1:0]        state_r;
    logic [CNT_W-1:0]  nib_cnt_r;
    logic [LCNT_W-1:0] lead_cnt_r;
    logic              sel_r;
    logic [OP_W-1:0]   a_sh_r;
    logic [OP_W-1:0]   b_sh_r;

    logic [OP_W-1:0]   op_a_r;
    logic [OP_W-1:0]   op_b_r;
    logic              op_sel_r;
    logic              op_valid_r;
    logic              frame_err_r;
    logic              overrun_r;

    logic [OP_W-1:0]   a_word_s;
    logic [OP_W-1:0]   b_word_s;
    logic              complete_s;
    logic              slot_free_s;

    // Shadow words with the incoming nibble merged into the lane selected by the counter
    always_comb begin
        a_word_s = a_sh_r;
        b_word_s = b_sh_r;
        for (int k = 0; k < NUM_NIB; k++) begin
            if (nib_cnt_r == CNT_W'(k)) begin
                a_word_s[k*NIB_W +: NIB_W] = in_a_nib;
                b_word_s[k*NIB_W +: NIB_W] = in_b_nib;
            end else begin
                a_word_s[k*NIB_W +: NIB_W] = a_sh_r[k*NIB_W +: NIB_W];
                b_word_s[k*NIB_W +: NIB_W] = b_sh_r[k*NIB_W +: NIB_W];
            end
        end
    end

    // Frame completion and output-slot availability for this edge
    always_comb begin
        complete_s  = (state_r == ST_CAP) && in_en && (nib_cnt_r == NIB_LAST);
        slot_free_s = !op_valid_r || core_bus.op_ready;
    end

    // Frame sequencer: setup count, nibble capture, abort detection
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            nib_cnt_r   <= {CNT_W{1'b0}};
            lead_cnt_r  <= {LCNT_W{1'b0}};
            sel_r       <= 1'b0;
            a_sh_r      <= {OP_W{1'b0}};
            b_sh_r      <= {OP_W{1'b0}};
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (in_en) begin
                        sel_r     <= in_sel;
                        nib_cnt_r <= {CNT_W{1'b0}};
                        if (LEAD > 1) begin
                            state_r    <= ST_LEAD;
                            lead_cnt_r <= LCNT_W'(1);
                        end else begin
                            state_r <= ST_CAP;
                        end
                    end
                end
                ST_LEAD: begin
                    if (!in_en) begin
                        state_r     <= ST_IDLE;
                        lead_cnt_r  <= {LCNT_W{1'b0}};
                        frame_err_r <= 1'b1;
                    end else if (lead_cnt_r == LEAD_LAST) begin
                        state_r    <= ST_CAP;
                        lead_cnt_r <= {LCNT_W{1'b0}};
                    end else begin
                        lead_cnt_r <= lead_cnt_r + 1'b1;
                    end
                end
                ST_CAP: begin
                    if (!in_en) begin
                        state_r     <= ST_IDLE;
                        nib_cnt_r   <= {CNT_W{1'b0}};
                        frame_err_r <= 1'b1;
                    end else begin
                        a_sh_r <= a_word_s;
                        b_sh_r <= b_word_s;
                        if (nib_cnt_r == NIB_LAST) begin
                            state_r   <= ST_WAIT_LOW;
                            nib_cnt_r <= {CNT_W{1'b0}};
                        end else begin
                            nib_cnt_r <= nib_cnt_r + 1'b1;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (!in_en) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    nib_cnt_r  <= {CNT_W{1'b0}};
                    lead_cnt_r <= {LCNT_W{1'b0}};
                end
            endcase
        end
    end

    // One-entry output slot: load on completion when free, else flag the dropped frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_a_r     <= {OP_W{1'b0}};
            op_b_r     <= {OP_W{1'b0}};
            op_sel_r   <= 1'b0;
            op_valid_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            overrun_r <= 1'b0;
            if (complete_s) begin
                if (slot_free_s) begin
                    op_a_r     <= a_word_s;
                    op_b_r     <= b_word_s;
                    op_sel_r   <= sel_r;
                    op_valid_r <= 1'b1;
                end else begin
                    overrun_r <= 1'b1;
                end
            end else if (op_valid_r && core_bus.op_ready) begin
                op_valid_r <= 1'b0;
            end
        end
    end

    assign core_bus.op_a     = op_a_r;
    assign core_bus.op_b     = op_b_r;
    assign core_bus.op_sel   = op_sel_r;
    assign core_bus.op_valid = op_valid_r;
    assign frame_err         = frame_err_r;
    assign overrun           = overrun_r;
    assign busy              = (state_r != ST_IDLE);
endmodule
